// File: rtl/kmeans_centroid_update.sv
// k-means centroid update: per-cluster sum/count accumulation, sequential
// restoring division into a shadow bank, then convergence check.
module kmeans_centroid_update #(
  parameter int input_data_width   = 8,
  parameter int dims_qty           = 5,
  parameter int centroids_qty      = 2,
  parameter int centroid_idx_width = 1,
  parameter int count_width        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  input  logic [dims_qty*input_data_width-1:0] in_data,
  input  logic [centroid_idx_width-1:0] in_centroid,
  input  logic in_last,
  input  logic [centroids_qty*dims_qty*input_data_width-1:0] old_centroids,
  output logic [centroids_qty*dims_qty*input_data_width-1:0] new_centroids,
  output logic busy,
  output logic done,
  output logic converged,
  output logic overflow
);

  localparam int W   = input_data_width;
  localparam int D   = dims_qty;
  localparam int K   = centroids_qty;
  localparam int CIW = centroid_idx_width;
  localparam int CW  = count_width;
  localparam int SW  = W + CW;
  localparam int KDW = K * D * W;
  localparam int DW  = (D > 1) ? $clog2(D) : 1;
  localparam int BW  = $clog2(SW + 1);
  localparam int RW  = CW + 1;
  localparam int NI  = 2 ** CIW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DIV,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [SW-1:0]  sum_q [K][D];
  logic [CW-1:0]  cnt_q [K];
  logic           ovf_q;
  logic [CIW-1:0] k_q;
  logic [DW-1:0]  d_q;
  logic [BW-1:0]  bit_q;
  logic [RW-1:0]  rem_q;
  logic [SW-1:0]  quo_q;
  logic [KDW-1:0] shd_q;
  logic [KDW-1:0] new_q;
  logic           conv_q;
  logic           done_q;
  logic           ovfo_q;

  logic [NI-1:0] idx_ok;
  logic          acc_ok;
  logic [CW-1:0] cnt_sel;
  logic          cnt_full;

  always_comb begin
    idx_ok = '0;
    for (int i = 0; i < K; i++) begin
      idx_ok[i] = 1'b1;
    end
  end

  assign acc_ok   = in_valid & idx_ok[in_centroid];
  assign cnt_sel  = cnt_q[in_centroid];
  assign cnt_full = &cnt_sel;

  // one restoring-division step on the (k_q,d_q) entry
  logic [CW-1:0] div_cnt;
  logic [RW-1:0] trial;
  logic          ge;
  logic [RW-1:0] rem_n;
  logic [SW-1:0] quo_n;
  logic [W-1:0]  old_kd;
  logic [W-1:0]  res;
  logic          last_bit;
  logic          last_kd;
  int            oidx;

  always_comb begin
    div_cnt  = cnt_q[k_q];
    trial    = {rem_q[CW-1:0], quo_q[SW-1]};
    ge       = (trial >= {1'b0, div_cnt});
    rem_n    = ge ? (trial - {1'b0, div_cnt}) : trial;
    quo_n    = {quo_q[SW-2:0], ge};
    oidx     = int'(k_q) * D + int'(d_q);
    old_kd   = old_centroids[oidx*W +: W];
    res      = (div_cnt == '0) ? old_kd : quo_n[W-1:0];
    last_bit = (bit_q == BW'(SW));
    last_kd  = (int'(k_q) == K - 1) && (int'(d_q) == D - 1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_ACC;
      S_ACC:  if (in_valid && in_last) state_d = S_DIV;
      S_DIV:  if (last_bit && last_kd) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < K; k++) begin
        cnt_q[k] <= '0;
        for (int d = 0; d < D; d++) begin
          sum_q[k][d] <= '0;
        end
      end
      ovf_q  <= 1'b0;
      k_q    <= '0;
      d_q    <= '0;
      bit_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      shd_q  <= '0;
      new_q  <= '0;
      conv_q <= 1'b0;
      done_q <= 1'b0;
      ovfo_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < K; k++) begin
              cnt_q[k] <= '0;
              for (int d = 0; d < D; d++) begin
                sum_q[k][d] <= '0;
              end
            end
            ovf_q <= 1'b0;
            k_q   <= '0;
            d_q   <= '0;
            bit_q <= '0;
          end
        end
        S_ACC: begin
          // saturated or out-of-range samples are dropped whole
          if (in_valid) begin
            if (acc_ok && !cnt_full) begin
              cnt_q[in_centroid] <= cnt_sel + 1'b1;
              for (int d = 0; d < D; d++) begin
                sum_q[in_centroid][d] <=
                  sum_q[in_centroid][d] + SW'(in_data[d*W +: W]);
              end
            end else begin
              ovf_q <= 1'b1;
            end
          end
        end
        S_DIV: begin
          if (bit_q == '0) begin
            rem_q <= '0;
            quo_q <= sum_q[k_q][d_q];
            bit_q <= BW'(1);
          end else begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            if (last_bit) begin
              shd_q[oidx*W +: W] <= res;
              bit_q <= '0;
              if (int'(d_q) == D - 1) begin
                d_q <= '0;
                k_q <= k_q + 1'b1;
              end else begin
                d_q <= d_q + 1'b1;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          new_q  <= shd_q;
          conv_q <= (shd_q == old_centroids);
          ovfo_q <= ovf_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign new_centroids = new_q;
  assign converged     = conv_q;
  assign overflow      = ovfo_q;
  assign done          = done_q;
  assign busy          = (state_q != S_IDLE) | done_q;

endmodule

// File: tb/tb_kmeans_centroid_update.sv
// Bench for kmeans_centroid_update: directed table, hand-written corner
// sequences and randomized passes against a plain-arithmetic mean model.
module tb_kmeans_centroid_update;

  localparam int W   = 8;
  localparam int D   = 2;
  localparam int K   = 2;
  localparam int CW  = 4;
  localparam int CIW = 1;
  localparam int T   = K * D * (W + CW + 1);
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic in_valid;
  logic [D*W-1:0] in_data;
  logic [CIW-1:0] in_centroid;
  logic in_last;
  logic [K*D*W-1:0] old_c;
  logic [K*D*W-1:0] new_c;
  logic busy, done, conv, ovf;

  kmeans_centroid_update #(
    .input_data_width  (W),
    .dims_qty          (D),
    .centroids_qty     (K),
    .centroid_idx_width(CIW),
    .count_width       (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_centroid  (in_centroid),
    .in_last      (in_last),
    .old_centroids(old_c),
    .new_centroids(new_c),
    .busy         (busy),
    .done         (done),
    .converged    (conv),
    .overflow     (ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] s0 [32];
  logic [7:0] s1 [32];
  int         sc [32];
  int         sn;

  typedef struct {
    int          n;
    logic [7:0]  a [16];
    logic [7:0]  b [16];
    int          c [16];
    logic [31:0] old;
    logic [31:0] exp_new;
    bit          exp_conv;
    bit          exp_ovf;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    in_centroid = '0;
  endtask

  task automatic add(input int v, input int a, input int b, input int c);
    tbl[v].a[tbl[v].n] = 8'(a);
    tbl[v].b[tbl[v].n] = 8'(b);
    tbl[v].c[tbl[v].n] = c;
    tbl[v].n++;
  endtask

  task automatic load(input int v);
    sn = tbl[v].n;
    for (int i = 0; i < sn; i++) begin
      s0[i] = tbl[v].a[i];
      s1[i] = tbl[v].b[i];
      sc[i] = tbl[v].c[i];
    end
  endtask

  // mean per (k,d) over accepted samples; a full counter rejects the sample
  task automatic model(input logic [31:0] old, output logic [31:0] nw,
                       output bit cv, output bit ov);
    int sum [2][2];
    int cnt [2];
    ov = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0;
      sum[k][0] = 0;
      sum[k][1] = 0;
    end
    for (int i = 0; i < sn; i++) begin
      if (cnt[sc[i]] == CMAX) begin
        ov = 1'b1;
      end else begin
        cnt[sc[i]]++;
        sum[sc[i]][0] += int'(s0[i]);
        sum[sc[i]][1] += int'(s1[i]);
      end
    end
    nw = '0;
    for (int k = 0; k < 2; k++) begin
      for (int d = 0; d < 2; d++) begin
        if (cnt[k] == 0) nw[(k*2+d)*8 +: 8] = old[(k*2+d)*8 +: 8];
        else nw[(k*2+d)*8 +: 8] = 8'(sum[k][d] / cnt[k]);
      end
    end
    cv = (nw == old);
  endtask

  task automatic feed(input bit noisy);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < sn; i++) begin
      in_valid = 1'b1;
      in_data = {s1[i], s0[i]};
      in_centroid = CIW'(sc[i]);
      in_last = (i == sn - 1);
      if (noisy && i == 0) start = 1'b1;
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic run_pass(input logic [31:0] old, input logic [31:0] en,
                          input bit ec, input bit eo, input bit noisy,
                          input string tag);
    int cyc;
    int extra;
    bit got;
    old_c = old;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_acc"}, busy, 1);
    for (int i = 0; i < sn; i++) begin
      in_valid = 1'b1;
      in_data = {s1[i], s0[i]};
      in_centroid = CIW'(sc[i]);
      in_last = (i == sn - 1);
      if (noisy && i == 0) start = 1'b1;
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (cyc < T + 20 && !got) begin
      if (noisy) begin
        in_valid = (cyc % 3 == 0);
        in_data = 16'($urandom);
        in_centroid = CIW'($urandom);
        start = (cyc == 10);
      end
      tick();
      cyc++;
      if (done) got = 1'b1;
    end
    idle_inputs();
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_latency"}, cyc, T + 1);
    chk({tag, "_new"}, new_c, en);
    chk({tag, "_conv"}, conv, ec);
    chk({tag, "_ovf"}, ovf, eo);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_end"}, busy, 0);
    if (noisy) begin
      extra = 0;
      for (int i = 0; i < 80; i++) begin
        tick();
        if (done) extra++;
      end
      chk({tag, "_no_redone"}, extra, 0);
      chk({tag, "_hold_new"}, new_c, en);
    end
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] en;
    bit ec;
    bit eo;

    for (int v = 0; v < 5; v++) tbl[v].n = 0;
    add(0, 10, 20, 0); add(0, 12, 22, 0); add(0, 14, 27, 0);
    add(0, 100, 200, 1);
    tbl[0].old = 32'h0101_0000; tbl[0].exp_new = 32'hC864_170C;
    tbl[0].exp_conv = 0; tbl[0].exp_ovf = 0;
    add(1, 5, 6, 0); add(1, 8, 9, 0); add(1, 10, 2, 0);
    tbl[1].old = 32'h0907_0000; tbl[1].exp_new = 32'h0907_0507;
    tbl[1].exp_conv = 0; tbl[1].exp_ovf = 0;
    add(2, 5, 6, 0); add(2, 8, 9, 0); add(2, 10, 2, 0);
    tbl[2].old = 32'h0907_0507; tbl[2].exp_new = 32'h0907_0507;
    tbl[2].exp_conv = 1; tbl[2].exp_ovf = 0;
    for (int i = 0; i < 16; i++) add(3, 1, 1, 0);
    tbl[3].old = 32'h0; tbl[3].exp_new = 32'h0000_0101;
    tbl[3].exp_conv = 0; tbl[3].exp_ovf = 1;
    add(4, 255, 0, 0); add(4, 1, 2, 1); add(4, 254, 255, 0);
    add(4, 3, 3, 1);
    tbl[4].old = 32'h0; tbl[4].exp_new = 32'h0202_7FFE;
    tbl[4].exp_conv = 0; tbl[4].exp_ovf = 0;

    idle_inputs();
    old_c = '0;
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_new", new_c, 0);
    chk("rst_conv", conv, 0);
    chk("rst_ovf", ovf, 0);

    in_valid = 1'b1;
    in_data = 16'h0505;
    in_last = 1'b1;
    repeat (4) tick();
    idle_inputs();
    chk("idle_valid_busy", busy, 0);
    chk("idle_valid_done", done, 0);
    chk("idle_valid_new", new_c, 0);

    for (int v = 0; v < 5; v++) begin
      load(v);
      run_pass(tbl[v].old, tbl[v].exp_new, tbl[v].exp_conv,
               tbl[v].exp_ovf, 1'b0, $sformatf("vec%0d", v));
    end

    load(1);
    run_pass(tbl[1].old, tbl[1].exp_new, tbl[1].exp_conv,
             tbl[1].exp_ovf, 1'b1, "noisy");

    prev = 32'h0;
    for (int p = 0; p < 8; p++) begin
      sn = $urandom_range(1, 24);
      for (int i = 0; i < sn; i++) begin
        s0[i] = 8'($urandom);
        s1[i] = 8'($urandom);
        sc[i] = (p % 3 == 0) ? 0 : int'($urandom_range(0, 1));
      end
      if (p % 2 == 0) prev = 32'($urandom);
      model(prev, en, ec, eo);
      run_pass(prev, en, ec, eo, 1'b0, $sformatf("rand%0d", p));
      prev = en;
    end

    load(0);
    old_c = tbl[0].old;
    feed(1'b0);
    repeat (20) tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_new", new_c, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_conv", conv, 0);
    begin
      int seen;
      seen = 0;
      repeat (3) begin
        tick();
        if (done || busy) seen++;
      end
      rst = 1'b1;
      repeat (60) begin
        tick();
        if (done || busy) seen++;
      end
      chk("mid_rst_quiet", seen, 0);
    end
    run_pass(tbl[0].old, tbl[0].exp_new, tbl[0].exp_conv,
             tbl[0].exp_ovf, 1'b0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
